// File: rtl/mem_burst_arbiter_if.sv
// Bundle of the two requester ports and the RAM port of mem_burst_arbiter.
// Signal suffixes are named from the arbiter's point of view.
interface mem_burst_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int LEN_W  = 4
);
  logic              req_a_i,   req_b_i;
  logic              we_a_i,    we_b_i;
  logic [ADDR_W-1:0] addr_a_i,  addr_b_i;
  logic [LEN_W-1:0]  len_a_i,   len_b_i;
  logic [7:0]        wdata_a_i, wdata_b_i;

  logic              gnt_a_o,    gnt_b_o;
  logic              beat_a_o,   beat_b_o;
  logic              done_a_o,   done_b_o;
  logic              rvalid_a_o, rvalid_b_o;
  logic [7:0]        rdata_o;

  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [7:0]        mem_wdata_o;
  logic [7:0]        mem_rdata_i;

  modport slave (
    input  req_a_i, req_b_i, we_a_i, we_b_i, addr_a_i, addr_b_i,
           len_a_i, len_b_i, wdata_a_i, wdata_b_i, mem_rdata_i,
    output gnt_a_o, gnt_b_o, beat_a_o, beat_b_o, done_a_o, done_b_o,
           rvalid_a_o, rvalid_b_o, rdata_o,
           mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output req_a_i, req_b_i, we_a_i, we_b_i, addr_a_i, addr_b_i,
           len_a_i, len_b_i, wdata_a_i, wdata_b_i, mem_rdata_i,
    input  gnt_a_o, gnt_b_o, beat_a_o, beat_b_o, done_a_o, done_b_o,
           rvalid_a_o, rvalid_b_o, rdata_o,
           mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_burst_arbiter.sv
// Two-requester round-robin burst arbiter in front of a single-port 8-bit RAM.
// A granted burst issues one beat per cycle with an incrementing, wrapping address.
module mem_burst_arbiter #(
  parameter int RAM_SIZE = 128,
  parameter int ADDR_W   = 7,
  parameter int LEN_W    = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  mem_burst_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BURST_A = 2'd1,
    BURST_B = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_SIZE - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [LEN_W-1:0]  cnt_q,   cnt_d;
  logic              we_q,    we_d;
  logic              last_b_q, last_b_d;  // 1: B was served most recently
  logic              rvalid_a_q, rvalid_b_q;

  logic              grant_a, grant_b;
  logic              beat_a, beat_b, done_a, done_b;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    last_b_d  = last_b_q;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    beat_a    = 1'b0;
    beat_b    = 1'b0;
    done_a    = 1'b0;
    done_b    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    case (state_q)
      IDLE: begin
        // rst_ni gates the grant so nothing pulses while reset is held with requests pending.
        grant_a = rst_ni && bus.req_a_i && (!bus.req_b_i || last_b_q);
        grant_b = rst_ni && bus.req_b_i && !grant_a;
        if (grant_a) begin
          state_d  = BURST_A;
          addr_d   = bus.addr_a_i;
          cnt_d    = bus.len_a_i;
          we_d     = bus.we_a_i;
          last_b_d = 1'b0;
        end else if (grant_b) begin
          state_d  = BURST_B;
          addr_d   = bus.addr_b_i;
          cnt_d    = bus.len_b_i;
          we_d     = bus.we_b_i;
          last_b_d = 1'b1;
        end
      end

      BURST_A, BURST_B: begin
        beat_a    = (state_q == BURST_A);
        beat_b    = (state_q == BURST_B);
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = beat_a ? bus.wdata_a_i : bus.wdata_b_i;
        done_a    = beat_a && (cnt_q == '0);
        done_b    = beat_b && (cnt_q == '0);
        addr_d    = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      last_b_q   <= 1'b1;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      last_b_q   <= last_b_d;
      rvalid_a_q <= beat_a && !we_q;
      rvalid_b_q <= beat_b && !we_q;
    end
  end

  assign bus.gnt_a_o     = grant_a;
  assign bus.gnt_b_o     = grant_b;
  assign bus.beat_a_o    = beat_a;
  assign bus.beat_b_o    = beat_b;
  assign bus.done_a_o    = done_a;
  assign bus.done_b_o    = done_b;
  assign bus.rvalid_a_o  = rvalid_a_q;
  assign bus.rvalid_b_o  = rvalid_b_q;
  // Read data is held at zero outside read-response cycles so the bus is quiet in reset.
  assign bus.rdata_o     = (rvalid_a_q || rvalid_b_q) ? bus.mem_rdata_i : '0;
  assign bus.mem_en_o    = mem_en;
  assign bus.mem_we_o    = mem_we;
  assign bus.mem_addr_o  = mem_addr;
  assign bus.mem_wdata_o = mem_wdata;

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Self-checking bench for mem_burst_arbiter: a behavioural RAM plus a transaction-level
// model that predicts every cycle of each burst from its start address, length and data.
module tb_mem_burst_arbiter;

  localparam int RAM_SIZE = 128;
  localparam int ADDR_W   = 7;
  localparam int LEN_W    = 4;
  localparam int MAX_WAIT = 40;

  typedef struct packed {
    logic [1:0]        gnt, beat, done, rvalid;  // index 0 = A, 1 = B
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata, rdata;
  } snap_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  logic [7:0] ram     [RAM_SIZE];
  logic [7:0] ref_mem [RAM_SIZE];

  mem_burst_arbiter_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  mem_burst_arbiter #(
    .RAM_SIZE(RAM_SIZE),
    .ADDR_W  (ADDR_W),
    .LEN_W   (LEN_W)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle-latency RAM
  always @(posedge clk) begin
    if (bus.mem_en_o) begin
      if (bus.mem_we_o) ram[bus.mem_addr_o] <= bus.mem_wdata_o;
      else              bus.mem_rdata_i     <= ram[bus.mem_addr_o];
    end
  end

  snap_t obs;
  assign obs = {bus.gnt_b_o, bus.gnt_a_o, bus.beat_b_o, bus.beat_a_o,
                bus.done_b_o, bus.done_a_o, bus.rvalid_b_o, bus.rvalid_a_o,
                bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.rdata_o};

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit who, input bit req, input bit we,
                       input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len);
    if (who) begin
      bus.req_b_i = req; bus.we_b_i = we; bus.addr_b_i = addr; bus.len_b_i = len;
    end else begin
      bus.req_a_i = req; bus.we_a_i = we; bus.addr_a_i = addr; bus.len_a_i = len;
    end
  endtask

  task automatic set_req(input bit who, input bit v);
    if (who) bus.req_b_i = v;
    else     bus.req_a_i = v;
  endtask

  task automatic set_wdata(input bit who, input logic [7:0] d);
    if (who) bus.wdata_b_i = d;
    else     bus.wdata_a_i = d;
  endtask

  task automatic reset_dut(input bit ra, input bit rb);
    rst_n = 1'b0;
    set_req(1'b0, ra);
    set_req(1'b1, rb);
    repeat (2) next_cycle();
    rst_n = 1'b1;
  endtask

  // Requests a burst from `who` and checks the grant, every beat, and (unless keep)
  // the trailing cycle. dbase < 0 selects random write data, otherwise dbase+i.
  task automatic do_burst(input bit who, input bit we, input logic [ADDR_W-1:0] addr,
                          input logic [LEN_W-1:0] len, input bit drop, input bit keep,
                          input bit now, input int dbase, input string name);
    snap_t      e, m;
    int         waited;
    logic [7:0] d;
    drive(who, 1'b1, we, addr, len);
    waited = 0;
    @(negedge clk);
    while (!(who ? bus.gnt_b_o : bus.gnt_a_o) && waited < MAX_WAIT) begin
      next_cycle();
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (waited >= MAX_WAIT || (now && waited != 0)) begin
      n_fail++;
      $display("FAIL %s grant_wait: got %0d idle cycles before grant, required %s",
               name, waited, now ? "0" : "fewer than limit");
      if (waited >= MAX_WAIT) return;
    end
    e = '0; e.gnt[who] = 1'b1;
    m = '1; m.rvalid = '0; m.rdata = '0; m.mem_we = 1'b0; m.mem_addr = '0; m.mem_wdata = '0;
    n_checks++;
    if ((obs & m) !== (e & m)) begin
      n_fail++;
      $display("FAIL %s grant_cycle: got %h required %h", name, obs & m, e & m);
    end
    next_cycle();
    // Inputs changed after the grant must have no effect on the running burst.
    drive(who, !drop, 1'($urandom), ADDR_W'($urandom), LEN_W'($urandom));
    for (int i = 0; i <= int'(len); i++) begin
      d = (dbase < 0) ? 8'($urandom) : 8'(dbase + i);
      set_wdata(who, d);
      @(negedge clk);
      e = '0;
      e.beat[who] = 1'b1;
      e.done[who] = (i == int'(len));
      e.mem_en    = 1'b1;
      e.mem_we    = we;
      e.mem_addr  = ADDR_W'((int'(addr) + i) % RAM_SIZE);
      e.mem_wdata = d;
      if (!we && i > 0) begin
        e.rvalid[who] = 1'b1;
        e.rdata       = ref_mem[(int'(addr) + i - 1) % RAM_SIZE];
      end
      m = '1;
      if (e.rvalid == '0) m.rdata = '0;
      n_checks++;
      if ((obs & m) !== (e & m)) begin
        n_fail++;
        $display("FAIL %s beat%0d: got %h required %h", name, i, obs & m, e & m);
      end
      if (we) ref_mem[(int'(addr) + i) % RAM_SIZE] = d;
      next_cycle();
    end
    if (!keep) begin
      set_req(who, 1'b0);
      @(negedge clk);
      e = '0;
      e.gnt[!who]   = who ? bus.req_a_i : bus.req_b_i;
      e.rvalid[who] = !we;
      if (!we) e.rdata = ref_mem[(int'(addr) + int'(len)) % RAM_SIZE];
      m = '1; m.mem_we = 1'b0; m.mem_addr = '0; m.mem_wdata = '0;
      if (we) m.rdata = '0;
      n_checks++;
      if ((obs & m) !== (e & m)) begin
        n_fail++;
        $display("FAIL %s after_done: got %h required %h", name, obs & m, e & m);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 7'h05, 4'd2);
    drive(1'b1, 1'b1, 1'b0, 7'h33, 4'd1);
    #2;
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_asserted: got %h required 0", obs);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== '0) begin
        n_fail++;
        $display("FAIL reset_held%0d: got %h required 0", c, obs);
      end
    end
    next_cycle();
    set_req(1'b0, 1'b0);
    set_req(1'b1, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL after_release: got %h required 0", obs);
    end
    next_cycle();
  endtask

  task automatic test_write_read();
    do_burst(1'b0, 1'b1, 7'h10, 4'd3, 1'b0, 1'b0, 1'b1, 'hA0, "single_write");
    do_burst(1'b0, 1'b0, 7'h10, 4'd3, 1'b0, 1'b0, 1'b1, -1,   "read_back");
  endtask

  task automatic test_wrap();
    do_burst(1'b1, 1'b1, 7'h7E, 4'd3, 1'b0, 1'b0, 1'b1, -1, "wrap_write");
    do_burst(1'b1, 1'b0, 7'h7E, 4'd3, 1'b0, 1'b0, 1'b1, -1, "wrap_read");
  endtask

  task automatic test_early_drop();
    do_burst(1'b0, 1'b1, ADDR_W'($urandom), 4'd15, 1'b1, 1'b0, 1'b1, -1, "early_drop");
  endtask

  task automatic test_back_to_back();
    do_burst(1'b0, 1'b1, ADDR_W'($urandom), LEN_W'($urandom), 1'b0, 1'b1, 1'b1, -1, "b2b_first");
    do_burst(1'b0, 1'b1, ADDR_W'($urandom), LEN_W'($urandom), 1'b0, 1'b0, 1'b1, -1, "b2b_second");
  endtask

  task automatic test_random();
    bit w, we, dr;
    for (int k = 0; k < 24; k++) begin
      w  = 1'($urandom);
      we = 1'($urandom);
      dr = ($urandom_range(3) == 0);
      do_burst(w, we, ADDR_W'($urandom), LEN_W'($urandom), dr, 1'b0, 1'b1, -1, "random");
    end
  endtask

  task automatic test_tie();
    reset_dut(1'b1, 1'b1);
    do_burst(1'b0, 1'b1, ADDR_W'($urandom), LEN_W'($urandom), 1'b0, 1'b1, 1'b1, -1, "tie_a1");
    do_burst(1'b1, 1'b1, ADDR_W'($urandom), LEN_W'($urandom), 1'b0, 1'b1, 1'b1, -1, "tie_b1");
    do_burst(1'b0, 1'b1, ADDR_W'($urandom), LEN_W'($urandom), 1'b0, 1'b1, 1'b1, -1, "tie_a2");
    do_burst(1'b1, 1'b1, ADDR_W'($urandom), LEN_W'($urandom), 1'b0, 1'b0, 1'b1, -1, "tie_b2");
  endtask

  task automatic test_reset_mid_burst();
    logic [ADDR_W-1:0] a;
    logic [7:0]        d;
    reset_dut(1'b0, 1'b0);
    a = ADDR_W'($urandom);
    drive(1'b0, 1'b1, 1'b1, a, 4'd7);
    @(negedge clk);
    n_checks++;
    if (bus.gnt_a_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid gnt_a: got %b required 1", bus.gnt_a_o);
    end
    next_cycle();
    set_req(1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      d = 8'($urandom);
      set_wdata(1'b0, d);
      @(negedge clk);
      n_checks++;
      if ({bus.mem_en_o, bus.beat_a_o, bus.mem_addr_o} !==
          {2'b11, ADDR_W'((int'(a) + i) % RAM_SIZE)}) begin
        n_fail++;
        $display("FAIL rst_mid beat%0d: got en=%b beat=%b addr=%h required en=1 beat=1 addr=%h",
                 i, bus.mem_en_o, bus.beat_a_o, bus.mem_addr_o,
                 ADDR_W'((int'(a) + i) % RAM_SIZE));
      end
      ref_mem[(int'(a) + i) % RAM_SIZE] = d;
      next_cycle();
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL rst_mid immediate: got %h required 0", obs);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== '0) begin
        n_fail++;
        $display("FAIL rst_mid held%0d: got %h required 0", c, obs);
      end
    end
    next_cycle();
    set_req(1'b1, 1'b1);
    rst_n = 1'b1;
    do_burst(1'b0, 1'b1, ADDR_W'($urandom), LEN_W'($urandom), 1'b0, 1'b0, 1'b1, -1, "rst_mid_tie");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, summary not reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < RAM_SIZE; i++) begin
      ram[i]     = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    bus.wdata_a_i = '0;
    bus.wdata_b_i = '0;
    test_reset();
    test_write_read();
    test_wrap();
    test_early_drop();
    test_back_to_back();
    test_random();
    test_tie();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
